ps2_scan_rx: RTL and testbench

Parametrised PS/2 keyboard receiver and scancode decoder, successor to the keyboard front end. Filters the raw PS/2 lines and deframes 11-bit frames with parity, stop and timeout checking. Folds E0/F0 prefixes into make/break/extended events and buffers them in a FIFO for the downstream consumer (RTC/PicoBlaze interface).

---
 rtl/ps2_scan_rx_if.sv | 13 +
 rtl/ps2_scan_rx.sv | 136 +++++++++++++
 tb/tb_ps2_scan_rx.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_scan_rx_if.sv
// ps2_scan_rx_if: event FIFO read port between the PS/2 receiver and its consumer
interface ps2_scan_rx_if #(
  parameter int FIFO_DEPTH = 4
);
  logic rd_en;
  logic ev_valid;
  logic [7:0] ev_code;
  logic ev_break;
  logic ev_ext;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  modport master (input rd_en, output ev_valid, ev_code, ev_break, ev_ext, fifo_count);
  modport slave (output rd_en, input ev_valid, ev_code, ev_break, ev_ext, fifo_count);
endinterface

// File: rtl/ps2_scan_rx.sv
// ps2_scan_rx: filtered PS/2 deframer with E0/F0 prefix folding into a fall-through event FIFO
module ps2_scan_rx #(
  parameter int FILTER_LEN = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2d,
  input  logic ps2c,
  input  logic rx_en,
  ps2_scan_rx_if.master ev,
  output logic rx_done_tick,
  output logic parity_err,
  output logic frame_err,
  output logic overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic c_s1, c_s2, d_s1, d_s2, fclk, fclk_n, strobe;
  logic [FILTER_LEN-1:0] hist, hist_n;
  logic [TW-1:0] tcnt;
  logic [2:0] cnt, cnt_n;
  logic [7:0] sh, sh_n;
  logic par, par_n, good, perr, ferr;
  logic ext_pend, brk_pend, prefix, push, pop, full, wr;
  logic [9:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] count;
  always_ff @(posedge clk) begin
    if (reset) begin
      {c_s1, c_s2, d_s1, d_s2} <= 4'b1111;
      hist <= '1;
      fclk <= 1'b1;
      strobe <= 1'b0;
    end else begin
      c_s1 <= ps2c;
      c_s2 <= c_s1;
      d_s1 <= ps2d;
      d_s2 <= d_s1;
      hist <= hist_n;
      fclk <= fclk_n;
      strobe <= fclk & ~fclk_n;
    end
  end
  // filtered clock only moves when the whole sample window agrees
  always_comb begin
    hist_n = {hist[FILTER_LEN-2:0], c_s2};
    fclk_n = &hist_n ? 1'b1 : (~|hist_n ? 1'b0 : fclk);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      par <= 1'b0;
      tcnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sh <= sh_n;
      par <= par_n;
      tcnt <= (state == IDLE || strobe) ? '0 : tcnt + TW'(1);
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sh_n = sh;
    par_n = par;
    good = 1'b0;
    perr = 1'b0;
    ferr = 1'b0;
    if (state != IDLE && tcnt == TW'(TIMEOUT_CYC)) begin
      state_n = IDLE;
      ferr = 1'b1;
    end else if (strobe) begin
      case (state)
        IDLE: if (rx_en && !d_s2) begin
          state_n = DATA;
          cnt_n = '0;
        end
        DATA: begin
          sh_n = {d_s2, sh[7:1]};
          cnt_n = cnt + 3'd1;
          state_n = (cnt == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          par_n = d_s2;
          state_n = STOP;
        end
        default: begin
          state_n = IDLE;
          ferr = !d_s2;
          perr = d_s2 && !(^{sh, par});
          good = d_s2 && (^{sh, par});
        end
      endcase
    end
  end
  assign prefix = (sh == 8'hE0) || (sh == 8'hF0);
  assign push = good && !prefix;
  assign full = count == CW'(FIFO_DEPTH);
  assign pop = ev.rd_en && count != '0;
  // when full, a simultaneous pop frees the head slot that wp already points at
  assign wr = push && (!full || pop);
  always_ff @(posedge clk) begin
    if (reset) begin
      {rx_done_tick, parity_err, frame_err, overflow} <= 4'b0;
      {ext_pend, brk_pend} <= 2'b00;
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      rx_done_tick <= good;
      parity_err <= perr;
      frame_err <= ferr;
      overflow <= push && full && !pop;
      if (good && sh == 8'hE0) ext_pend <= 1'b1;
      else if (good && sh == 8'hF0) brk_pend <= 1'b1;
      else if (push || perr || ferr) {ext_pend, brk_pend} <= 2'b00;
      if (wr) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      count <= count + CW'(wr) - CW'(pop);
    end
  end
  always_ff @(posedge clk) if (wr) mem[wp] <= {ext_pend, brk_pend, sh};
  assign ev.ev_valid = count != '0;
  assign ev.ev_code = ev.ev_valid ? mem[rp][7:0] : 8'h00;
  assign ev.ev_break = ev.ev_valid && mem[rp][8];
  assign ev.ev_ext = ev.ev_valid && mem[rp][9];
  assign ev.fifo_count = count;
endmodule

// File: tb/tb_ps2_scan_rx.sv
// tb_ps2_scan_rx: directed plus randomized PS/2 frames checked against a queue-based event model
module tb_ps2_scan_rx;
  localparam int FL = 8;
  localparam int FD = 4;
  localparam int TO = 2000;
  localparam int H = 40;
  logic clk = 0, reset = 1, ps2d = 1, ps2c = 1, rx_en = 1;
  logic rx_done_tick, parity_err, frame_err, overflow;
  int n_cmp = 0, n_bad = 0;
  int n_done = 0, n_perr = 0, n_ferr = 0, n_ovf = 0;
  int e_done = 0, e_perr = 0, e_ferr = 0, e_ovf = 0;
  logic ext_m = 0, brk_m = 0;
  logic [9:0] q[$];
  ps2_scan_rx_if #(.FIFO_DEPTH(FD)) ev ();
  ps2_scan_rx #(.FILTER_LEN(FL), .FIFO_DEPTH(FD), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c), .rx_en(rx_en), .ev(ev.master),
    .rx_done_tick(rx_done_tick), .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rx_done_tick) n_done++;
    if (parity_err) n_perr++;
    if (frame_err) n_ferr++;
    if (overflow) n_ovf++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clk_bit(input logic b, input logic g);
    ps2d = b;
    ps2c = 1;
    repeat (H / 2) @(posedge clk);
    if (g) begin
      ps2c = 0;
      repeat (3) @(posedge clk);
      ps2c = 1;
    end
    repeat (H / 2) @(posedge clk);
    ps2c = 0;
    repeat (H) @(posedge clk);
  endtask
  task automatic idle_line(input int n);
    ps2c = 1;
    ps2d = 1;
    repeat (n) @(posedge clk);
  endtask
  task automatic model_frame(input logic [7:0] b, input logic bad_par, input logic stop);
    if (!stop) begin
      e_ferr++;
      {ext_m, brk_m} = 2'b00;
    end else if (bad_par) begin
      e_perr++;
      {ext_m, brk_m} = 2'b00;
    end else begin
      e_done++;
      if (b == 8'hE0) ext_m = 1;
      else if (b == 8'hF0) brk_m = 1;
      else begin
        if (q.size() < FD) q.push_back({ext_m, brk_m, b});
        else e_ovf++;
        {ext_m, brk_m} = 2'b00;
      end
    end
  endtask
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop,
                            input logic glitch, input logic en_mid);
    clk_bit(1'b0, 1'b0);
    rx_en = en_mid;
    for (int i = 0; i < 8; i++) clk_bit(b[i], glitch && i == 3);
    clk_bit(~^b ^ bad_par, 1'b0);
    clk_bit(stop, 1'b0);
    rx_en = 1;
    idle_line(3 * H);
    model_frame(b, bad_par, stop);
  endtask
  task automatic check_state(input string tag);
    @(negedge clk);
    chk({tag, ".count"}, 32'(ev.fifo_count), 32'(q.size()));
    chk({tag, ".valid"}, 32'(ev.ev_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk({tag, ".code"}, 32'(ev.ev_code), 32'(q[0][7:0]));
      chk({tag, ".brk"}, 32'(ev.ev_break), 32'(q[0][8]));
      chk({tag, ".ext"}, 32'(ev.ev_ext), 32'(q[0][9]));
    end
    chk({tag, ".done"}, 32'(n_done), 32'(e_done));
    chk({tag, ".perr"}, 32'(n_perr), 32'(e_perr));
    chk({tag, ".ferr"}, 32'(n_ferr), 32'(e_ferr));
    chk({tag, ".ovf"}, 32'(n_ovf), 32'(e_ovf));
  endtask
  task automatic pop_one(input string tag);
    @(negedge clk);
    if (q.size() != 0) chk({tag, ".head"}, 32'({ev.ev_ext, ev.ev_break, ev.ev_code}), 32'(q[0]));
    rx_en = rx_en;
    ev.rd_en = 1;
    @(negedge clk);
    ev.rd_en = 0;
    if (q.size() != 0) void'(q.pop_front());
  endtask
  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: run exceeded cycle bound");
    $fatal(1);
  end
  initial begin
    logic [7:0] b;
    ev.rd_en = 0;
    repeat (4) @(posedge clk);
    reset = 0;
    @(negedge clk);
    chk("rst.valid", 32'(ev.ev_valid), 0);
    chk("rst.count", 32'(ev.fifo_count), 0);
    chk("rst.pulses", 32'({rx_done_tick, parity_err, frame_err, overflow}), 0);
    idle_line(2 * H);
    send_frame(8'hF0, 0, 1, 0, 1);
    send_frame(8'h2B, 0, 1, 0, 1);
    check_state("t1");
    pop_one("t1");
    send_frame(8'hE0, 0, 1, 0, 1);
    send_frame(8'hF0, 0, 1, 0, 1);
    send_frame(8'h74, 0, 1, 0, 1);
    send_frame(8'h1C, 0, 1, 0, 1);
    check_state("t2");
    pop_one("t2a");
    pop_one("t2b");
    send_frame(8'hF0, 0, 1, 0, 1);
    send_frame(8'h1C, 1, 1, 0, 1);
    check_state("t3a");
    send_frame(8'h1C, 0, 1, 0, 1);
    check_state("t3b");
    pop_one("t3");
    clk_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) clk_bit(1'b1, 1'b0);
    idle_line(TO + 500);
    e_ferr++;
    {ext_m, brk_m} = 2'b00;
    check_state("t4a");
    send_frame(8'h1C, 0, 1, 0, 1);
    check_state("t4b");
    pop_one("t4");
    send_frame(8'h15, 0, 1, 0, 1);
    send_frame(8'h1D, 0, 1, 0, 1);
    send_frame(8'h24, 0, 1, 0, 1);
    send_frame(8'h2D, 0, 1, 0, 1);
    send_frame(8'h2C, 0, 1, 0, 1);
    check_state("t5");
    for (int i = 0; i < 4; i++) pop_one("t5pop");
    check_state("t5e");
    send_frame(8'h5A, 0, 1, 1, 1);
    check_state("t6g");
    pop_one("t6g");
    send_frame(8'h33, 0, 1, 0, 1);
    clk_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) clk_bit(1'b1, 1'b0);
    ps2c = 1;
    ps2d = 1;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    q.delete();
    {ext_m, brk_m} = 2'b00;
    chk("t6r.valid", 32'(ev.ev_valid), 0);
    chk("t6r.count", 32'(ev.fifo_count), 0);
    chk("t6r.code", 32'({ev.ev_code, ev.ev_break, ev.ev_ext}), 0);
    chk("t6r.pulses", 32'({rx_done_tick, parity_err, frame_err, overflow}), 0);
    idle_line(3 * H);
    send_frame(8'h42, 0, 1, 0, 1);
    check_state("t6f");
    for (int k = 0; k < 25; k++) begin
      int r;
      r = int'($urandom_range(0, 99));
      b = r < 10 ? 8'hE0 : r < 25 ? 8'hF0 : 8'($urandom_range(1, 255));
      if ($urandom_range(0, 9) == 0) begin
        rx_en = 0;
        clk_bit(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) clk_bit(1'b1, 1'b0);
        rx_en = 1;
        idle_line(3 * H);
      end else begin
        send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 11) != 0, 1'b0,
                   1'($urandom_range(0, 1)));
      end
      check_state("rnd");
      if ($urandom_range(0, 1) == 1 && q.size() != 0) pop_one("rnd");
    end
    while (q.size() != 0) pop_one("drain");
    check_state("end");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
